instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/seq_pkg.sv | 40 ++++
 rtl/branch_unit.sv | 40 ++++
 rtl/instr_sequencer.sv | 101 ++++++++++
 tb/tb_instr_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and field positions for the instruction sequencer.
// The single-step PAUSE state exists only when SEQ_STEP_EN is defined.
package seq_pkg;

  localparam int PC_W = 8;
  localparam int IR_W = 16;

  // Opcode occupies IR[15:9]; the bit positions below are relative to the opcode
  localparam int OPC_MSB      = 15;
  localparam int OPC_LSB      = 9;
  localparam int OPC_W        = OPC_MSB - OPC_LSB + 1;
  localparam int BR_CLASS_HI  = 6;
  localparam int BR_CLASS_LO  = 5;
  localparam int BR_UNCOND    = 4;
  localparam int BR_FLAG_SEL  = 0;

  // Branch offset is split: high half IR[8:6], low half IR[2:0]
  localparam int OFF_HI_MSB   = 8;
  localparam int OFF_HI_LSB   = 6;
  localparam int OFF_LO_MSB   = 2;
  localparam int OFF_LO_LSB   = 0;
  localparam int OFF_W        = 6;

  localparam logic [IR_W-1:0] HALT_IR = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
`ifdef SEQ_STEP_EN
    , ST_PAUSE
`endif
  } seq_state_t;

  function automatic logic [PC_W-1:0] sext_offset(input logic [OFF_W-1:0] off);
    return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/branch_unit.sv
// Combinational next-PC computation: halt detect, jump, conditional branch
// on Z or N with a 6-bit signed offset, or sequential increment (mod 256).
module branch_unit
  import seq_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [IR_W-1:0] ir,
  input  logic            z,
  input  logic            n,
  input  logic [PC_W-1:0] ra_value,
  output logic [PC_W-1:0] next_pc,
  output logic            is_halt
);

  logic [OPC_W-1:0] opcode;
  logic [OFF_W-1:0] offset;
  logic             is_branch;
  logic             flag;

  assign opcode    = ir[OPC_MSB:OPC_LSB];
  assign offset    = {ir[OFF_HI_MSB:OFF_HI_LSB], ir[OFF_LO_MSB:OFF_LO_LSB]};
  assign is_branch = (opcode[BR_CLASS_HI:BR_CLASS_LO] == 2'b11);
  assign flag      = opcode[BR_FLAG_SEL] ? n : z;
  assign is_halt   = (ir == HALT_IR);

  always_comb begin
    next_pc = pc + 8'd1;
    if (is_halt) begin
      // Halt keeps PC; it overrides the branch-class decode it would match
      next_pc = pc;
    end else if (is_branch) begin
      if (opcode[BR_UNCOND]) begin
        next_pc = ra_value;
      end else if (flag) begin
        next_pc = pc + sext_offset(offset);
      end
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: IDLE -> FETCH -> EXEC -> FETCH ... until HALT.
// Defining SEQ_STEP_EN adds a STEP input and a PAUSE state after each EXEC.
module instr_sequencer
  import seq_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              IMEM_REQ,
  output logic [PC_W-1:0]   IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [IR_W-1:0]   IMEM_DATA,
  output logic [IR_W-1:0]   IR,
  output logic              EXEC_EN,
  input  logic              Z,
  input  logic              N,
  input  logic [PC_W-1:0]   RA_VALUE,
`ifdef SEQ_STEP_EN
  input  logic              STEP,
`endif
  output logic              BUSY,
  output logic              HALTED
);

  seq_state_t      state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [IR_W-1:0] ir_reg, ir_next;
  logic [PC_W-1:0] branch_pc;
  logic            ir_is_halt;

  branch_unit u_branch (
    .pc       (pc_reg),
    .ir       (ir_reg),
    .z        (Z),
    .n        (N),
    .ra_value (RA_VALUE),
    .next_pc  (branch_pc),
    .is_halt  (ir_is_halt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    case (state_reg)
      ST_IDLE: begin
        if (START) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (IMEM_ACK) begin
          ir_next    = IMEM_DATA;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ir_is_halt) begin
          state_next = ST_HALT;
        end else begin
          pc_next = branch_pc;
`ifdef SEQ_STEP_EN
          state_next = ST_PAUSE;
`else
          state_next = ST_FETCH;
`endif
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
`ifdef SEQ_STEP_EN
      ST_PAUSE: begin
        if (STEP) state_next = ST_FETCH;
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state so reset clears them at once
  assign IMEM_REQ  = (state_reg == ST_FETCH);
  assign IMEM_ADDR = pc_reg;
  assign IR        = ir_reg;
  assign EXEC_EN   = (state_reg == ST_EXEC);
  assign HALTED    = (state_reg == ST_HALT);
  assign BUSY      = (state_reg != ST_IDLE) && (state_reg != ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (default and SEQ_STEP_EN builds).
module tb_instr_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        IMEM_REQ;
  logic [7:0]  IMEM_ADDR;
  logic        IMEM_ACK;
  logic [15:0] IMEM_DATA;
  logic [15:0] IR;
  logic        EXEC_EN;
  logic        Z;
  logic        N;
  logic [7:0]  RA_VALUE;
  logic        BUSY;
  logic        HALTED;
`ifdef SEQ_STEP_EN
  logic        STEP;
`endif

  int total;
  int bad;

  instr_sequencer dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .IMEM_REQ  (IMEM_REQ),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_ACK  (IMEM_ACK),
    .IMEM_DATA (IMEM_DATA),
    .IR        (IR),
    .EXEC_EN   (EXEC_EN),
    .Z         (Z),
    .N         (N),
    .RA_VALUE  (RA_VALUE),
`ifdef SEQ_STEP_EN
    .STEP      (STEP),
`endif
    .BUSY      (BUSY),
    .HALTED    (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One instruction: fetch at exp_addr (ack after 'delay' wait cycles), execute, then check next PC.
  task automatic fetch_exec(input string name, input logic [7:0] exp_addr, input logic [15:0] data,
                            input int delay, input logic z, input logic n, input logic [7:0] ra,
                            input logic [7:0] exp_next);
    total++;
    if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== exp_addr || EXEC_EN !== 1'b0) begin
      bad++;
      $display("FAIL %s fetch: req=%b addr=%h exec=%b, want req=1 addr=%h exec=0",
               name, IMEM_REQ, IMEM_ADDR, EXEC_EN, exp_addr);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge CLK);
      total++;
      if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== exp_addr || EXEC_EN !== 1'b0) begin
        bad++;
        $display("FAIL %s wait%0d: req=%b addr=%h exec=%b, want req=1 addr=%h exec=0",
                 name, i, IMEM_REQ, IMEM_ADDR, EXEC_EN, exp_addr);
      end
    end
    IMEM_DATA = data;
    IMEM_ACK  = 1'b1;
    Z = z;
    N = n;
    RA_VALUE = ra;
    @(negedge CLK);
    IMEM_ACK  = 1'b0;
    IMEM_DATA = 16'h5A5A;
    total++;
    if (EXEC_EN !== 1'b1 || IMEM_REQ !== 1'b0 || IR !== data) begin
      bad++;
      $display("FAIL %s exec: exec=%b req=%b ir=%h, want exec=1 req=0 ir=%h",
               name, EXEC_EN, IMEM_REQ, IR, data);
    end
    @(negedge CLK);
`ifdef SEQ_STEP_EN
    if (data != 16'hFFFF) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (IMEM_REQ !== 1'b0 || BUSY !== 1'b1 || IMEM_ADDR !== exp_next) begin
          bad++;
          $display("FAIL %s pause%0d: req=%b busy=%b addr=%h, want req=0 busy=1 addr=%h",
                   name, i, IMEM_REQ, BUSY, IMEM_ADDR, exp_next);
        end
        @(negedge CLK);
      end
      STEP = 1'b1;
      @(negedge CLK);
      STEP = 1'b0;
    end
`endif
    total++;
    if (IMEM_ADDR !== exp_next || (data != 16'hFFFF && IMEM_REQ !== 1'b1)) begin
      bad++;
      $display("FAIL %s next: addr=%h req=%b, want addr=%h", name, IMEM_ADDR, IMEM_REQ, exp_next);
    end
    $display("txn %s: addr=%h ir=%h -> next=%h", name, exp_addr, data, IMEM_ADDR);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #1;
    total++;
    if (IMEM_REQ !== 1'b0 || EXEC_EN !== 1'b0 || BUSY !== 1'b0 || HALTED !== 1'b0 ||
        IR !== 16'h0000 || IMEM_ADDR !== 8'h00) begin
      bad++;
      $display("FAIL reset_values: req=%b exec=%b busy=%b halted=%b ir=%h addr=%h, want all zero",
               IMEM_REQ, EXEC_EN, BUSY, HALTED, IR, IMEM_ADDR);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    IMEM_ACK  = 1'b1;
    IMEM_DATA = 16'h1234;
    @(negedge CLK);
    @(negedge CLK);
    IMEM_ACK = 1'b0;
    total++;
    if (IMEM_REQ !== 1'b0 || BUSY !== 1'b0 || IR !== 16'h0000 || IMEM_ADDR !== 8'h00) begin
      bad++;
      $display("FAIL idle_hold: req=%b busy=%b ir=%h addr=%h, want req=0 busy=0 ir=0000 addr=00",
               IMEM_REQ, BUSY, IR, IMEM_ADDR);
    end
    $display("txn reset: idle with pc=%h", IMEM_ADDR);
  endtask

  task automatic test_zero_wait();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    total++;
    if (BUSY !== 1'b1) begin
      bad++;
      $display("FAIL start_busy: busy=%b, want 1", BUSY);
    end
    fetch_exec("zw0", 8'h00, 16'h0000, 0, 1'b0, 1'b0, 8'h00, 8'h01);
    fetch_exec("zw1", 8'h01, 16'h0000, 0, 1'b0, 1'b0, 8'h00, 8'h02);
    fetch_exec("zw2", 8'h02, 16'h0000, 0, 1'b0, 1'b0, 8'h00, 8'h03);
  endtask

  task automatic test_delayed_ack();
    fetch_exec("dly3", 8'h03, 16'h0000, 3, 1'b0, 1'b0, 8'h00, 8'h04);
  endtask

  task automatic test_branch();
    fetch_exec("jmp10",   8'h04, 16'hE000, 0, 1'b0, 1'b0, 8'h10, 8'h10);
    fetch_exec("bz_tk",   8'h10, 16'hC1C6, 0, 1'b1, 1'b0, 8'h99, 8'h0E);
    fetch_exec("jmp10b",  8'h0E, 16'hE000, 0, 1'b0, 1'b0, 8'h10, 8'h10);
    fetch_exec("bz_nt",   8'h10, 16'hC1C6, 0, 1'b0, 1'b1, 8'h99, 8'h11);
    fetch_exec("bn_tk",   8'h11, 16'hC3C6, 0, 1'b0, 1'b1, 8'h99, 8'h0F);
    fetch_exec("bn_nt",   8'h0F, 16'hC3C6, 0, 1'b1, 1'b0, 8'h99, 8'h10);
    fetch_exec("jmp02",   8'h10, 16'hE000, 0, 1'b0, 1'b0, 8'h02, 8'h02);
    fetch_exec("bz_m4",   8'h02, 16'hC1C4, 0, 1'b1, 1'b0, 8'h99, 8'hFE);
    fetch_exec("inc_fe",  8'hFE, 16'h0000, 0, 1'b1, 1'b1, 8'h99, 8'hFF);
    fetch_exec("wrap_ff", 8'hFF, 16'h0000, 0, 1'b1, 1'b1, 8'h99, 8'h00);
    fetch_exec("bz_p31",  8'h00, 16'hC0C7, 0, 1'b1, 1'b0, 8'h99, 8'h1F);
    fetch_exec("nonbr",   8'h1F, 16'h80C7, 0, 1'b1, 1'b1, 8'h99, 8'h20);
    fetch_exec("jmpA5",   8'h20, 16'hE000, 0, 1'b0, 1'b0, 8'hA5, 8'hA5);
    fetch_exec("jmp20",   8'hA5, 16'hE000, 0, 1'b1, 1'b1, 8'h20, 8'h20);
  endtask

  task automatic test_halt();
    fetch_exec("halt", 8'h20, 16'hFFFF, 0, 1'b1, 1'b1, 8'h55, 8'h20);
    START     = 1'b1;
    IMEM_ACK  = 1'b1;
    IMEM_DATA = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (HALTED !== 1'b1 || IMEM_REQ !== 1'b0 || BUSY !== 1'b0 || EXEC_EN !== 1'b0 ||
          IMEM_ADDR !== 8'h20) begin
        bad++;
        $display("FAIL halt_hold%0d: halted=%b req=%b busy=%b exec=%b addr=%h, want 1 0 0 0 20",
                 i, HALTED, IMEM_REQ, BUSY, EXEC_EN, IMEM_ADDR);
      end
      @(negedge CLK);
    end
    START    = 1'b0;
    IMEM_ACK = 1'b0;
    $display("txn halt_hold: halted=%b addr=%h", HALTED, IMEM_ADDR);
  endtask

  task automatic test_reset_mid_fetch();
    RST_N = 1'b0;
    #1;
    total++;
    if (HALTED !== 1'b0 || IMEM_ADDR !== 8'h00) begin
      bad++;
      $display("FAIL reset_from_halt: halted=%b addr=%h, want 0 00", HALTED, IMEM_ADDR);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    fetch_exec("jmp40", 8'h00, 16'hE000, 0, 1'b0, 1'b0, 8'h40, 8'h40);
    #2;
    RST_N = 1'b0;
    #1;
    total++;
    if (IMEM_REQ !== 1'b0 || BUSY !== 1'b0 || IMEM_ADDR !== 8'h00 || IR !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid_fetch: req=%b busy=%b addr=%h ir=%h, want 0 0 00 0000",
               IMEM_REQ, BUSY, IMEM_ADDR, IR);
    end
    @(negedge CLK);
    RST_N     = 1'b1;
    IMEM_ACK  = 1'b1;
    IMEM_DATA = 16'hE000;
    RA_VALUE  = 8'h77;
    @(negedge CLK);
    @(negedge CLK);
    IMEM_ACK = 1'b0;
    total++;
    if (IMEM_REQ !== 1'b0 || EXEC_EN !== 1'b0 || BUSY !== 1'b0 || IR !== 16'h0000 ||
        IMEM_ADDR !== 8'h00) begin
      bad++;
      $display("FAIL late_ack: req=%b exec=%b busy=%b ir=%h addr=%h, want 0 0 0 0000 00",
               IMEM_REQ, EXEC_EN, BUSY, IR, IMEM_ADDR);
    end
    $display("txn reset_mid_fetch: addr=%h ir=%h", IMEM_ADDR, IR);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    fetch_exec("restart", 8'h00, 16'h0000, 0, 1'b0, 1'b0, 8'h00, 8'h01);
  endtask

  task automatic test_start_ignored();
    START = 1'b1;
    fetch_exec("start_busy", 8'h01, 16'h0000, 1, 1'b0, 1'b0, 8'h00, 8'h02);
    START = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    RST_N     = 1'b0;
    START     = 1'b0;
    IMEM_ACK  = 1'b0;
    IMEM_DATA = 16'h0000;
    Z         = 1'b0;
    N         = 1'b0;
    RA_VALUE  = 8'h00;
`ifdef SEQ_STEP_EN
    STEP      = 1'b0;
`endif
    @(negedge CLK);
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_branch();
    test_halt();
    test_reset_mid_fetch();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
